// File: rtl/decoder_scan_ctrl.sv
// ----------------------------------------------------------------------------
// decoder_scan_ctrl
//
// Drives the A/B/C select pins and the enable pin of a 3-8 decoder. It cycles
// through the positions enabled in digit_mask, for example the digit strobes
// of a multiplexed seven-segment display. Each position is shown for
// SCAN_DIV cycles. Before it is shown, it is preceded by BLANK_CYC blanked
// cycles. The select lines only move on entry to the blanking gap, so a
// visible position never glitches.
//
// Optional feature: define SCAN_FRAME_CNT_EN to add the frame_cnt[7:0]
// output. It counts frame_done pulses, wraps from 255 to 0, and clears on
// reset and whenever the scanner drops to idle.
//
// Ports
//   clk         in   system clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   en          in   scan enable (level)
//   digit_mask  in   [7:0] bit i = 1 -> position i is scanned
//   sel_a       out  decoder select MSB (scan_idx[2])
//   sel_b       out  decoder select     (scan_idx[1])
//   sel_c       out  decoder select LSB (scan_idx[0])
//   blank       out  1 = decoder disabled / output suppressed
//   scan_idx    out  [2:0] current position
//   frame_done  out  one-cycle pulse on the first blank cycle after a wrap
//   frame_cnt   out  [7:0] frame counter (SCAN_FRAME_CNT_EN only)
// ----------------------------------------------------------------------------
module decoder_scan_ctrl #(
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_CYC = 8,
    parameter int DIV_W     = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [7:0] digit_mask,
    output logic       sel_a,
    output logic       sel_b,
    output logic       sel_c,
    output logic       blank,
    output logic [2:0] scan_idx,
`ifdef SCAN_FRAME_CNT_EN
    output logic [7:0] frame_cnt,
`endif
    output logic       frame_done
);

    typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

    localparam logic [DIV_W-1:0] DWELL_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [7:0]       BLANK_LAST = 8'(BLANK_CYC - 1);

    state_t           state_reg;
    logic [2:0]       idx_reg;
    logic             blank_reg;
    logic             frame_done_reg;
    logic [DIV_W-1:0] dwell_cnt_reg;
    logic [7:0]       blank_cnt_reg;
`ifdef SCAN_FRAME_CNT_EN
    logic [7:0]       frame_cnt_reg;
`endif

    logic       stop;
    logic [7:0] rot_mask;
    logic [2:0] step;
    logic [2:0] idx_next;
    logic       wrap_next;
    logic [2:0] first_idx;

    assign stop = !en || (digit_mask == 8'h00);

    // rot_mask[gi] is the mask bit that lies gi+1 positions after idx_reg,
    // taken cyclically. Bit 7 therefore wraps back onto idx_reg itself,
    // which handles the single-bit mask case.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_rot
            localparam logic [2:0] OFS = 3'((gi + 1) % 8);
            logic [2:0] pos;
            assign pos          = idx_reg + OFS;
            assign rot_mask[gi] = digit_mask[pos];
        end
    endgenerate

    // Find the nearest set bit strictly after idx_reg. A result at or below
    // the current index means the search went past 7 (or came back to the
    // same index), which marks the end of a frame.
    always_comb begin
        step = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (rot_mask[i]) step = 3'(i);
        end
        idx_next  = idx_reg + step + 3'd1;
        wrap_next = (idx_next <= idx_reg);
    end

    // Lowest set mask bit, used when a scan starts from idle.
    always_comb begin
        first_idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (digit_mask[i]) first_idx = 3'(i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            idx_reg        <= 3'd0;
            blank_reg      <= 1'b1;
            frame_done_reg <= 1'b0;
            dwell_cnt_reg  <= '0;
            blank_cnt_reg  <= '0;
`ifdef SCAN_FRAME_CNT_EN
            frame_cnt_reg  <= 8'd0;
`endif
        end else if (stop) begin
            // Losing the enable or the whole mask overrides both counters.
            state_reg      <= IDLE;
            idx_reg        <= 3'd0;
            blank_reg      <= 1'b1;
            frame_done_reg <= 1'b0;
            dwell_cnt_reg  <= '0;
            blank_cnt_reg  <= '0;
`ifdef SCAN_FRAME_CNT_EN
            frame_cnt_reg  <= 8'd0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    state_reg      <= BLANK;
                    idx_reg        <= first_idx;
                    blank_reg      <= 1'b1;
                    frame_done_reg <= 1'b0;
                    dwell_cnt_reg  <= '0;
                    blank_cnt_reg  <= '0;
                end
                BLANK: begin
                    // frame_done covers only the first blank cycle.
                    frame_done_reg <= 1'b0;
                    if (blank_cnt_reg == BLANK_LAST) begin
                        state_reg     <= SHOW;
                        blank_reg     <= 1'b0;
                        blank_cnt_reg <= '0;
                    end else begin
                        blank_cnt_reg <= blank_cnt_reg + 8'd1;
                    end
                end
                SHOW: begin
                    if (dwell_cnt_reg == DWELL_LAST) begin
                        // The select lines move only here, together with
                        // blank rising, so they never change while visible.
                        state_reg      <= BLANK;
                        blank_reg      <= 1'b1;
                        idx_reg        <= idx_next;
                        frame_done_reg <= wrap_next;
                        dwell_cnt_reg  <= '0;
`ifdef SCAN_FRAME_CNT_EN
                        if (wrap_next) frame_cnt_reg <= frame_cnt_reg + 8'd1;
`endif
                    end else begin
                        dwell_cnt_reg <= dwell_cnt_reg + 1'b1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    idx_reg   <= 3'd0;
                    blank_reg <= 1'b1;
                end
            endcase
        end
    end

    assign sel_a      = idx_reg[2];
    assign sel_b      = idx_reg[1];
    assign sel_c      = idx_reg[0];
    assign scan_idx   = idx_reg;
    assign blank      = blank_reg;
    assign frame_done = frame_done_reg;
`ifdef SCAN_FRAME_CNT_EN
    assign frame_cnt  = frame_cnt_reg;
`endif

endmodule

// File: tb/tb_decoder_scan_ctrl.sv
// ----------------------------------------------------------------------------
// tb_decoder_scan_ctrl
//
// Directed bench for decoder_scan_ctrl with SCAN_DIV=4 and BLANK_CYC=2, so
// each position lasts 6 cycles: 2 blanked cycles followed by 4 shown cycles.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// ----------------------------------------------------------------------------
module tb_decoder_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [7:0] digit_mask;
    logic       sel_a, sel_b, sel_c;
    logic       blank;
    logic [2:0] scan_idx;
    logic       frame_done;
`ifdef SCAN_FRAME_CNT_EN
    logic [7:0] frame_cnt;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    decoder_scan_ctrl #(
        .SCAN_DIV (4),
        .BLANK_CYC(2),
        .DIV_W    (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .digit_mask(digit_mask),
        .sel_a     (sel_a),
        .sel_b     (sel_b),
        .sel_c     (sel_c),
        .blank     (blank),
        .scan_idx  (scan_idx),
`ifdef SCAN_FRAME_CNT_EN
        .frame_cnt (frame_cnt),
`endif
        .frame_done(frame_done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Checks the blank, select and pulse outputs in the idle state.
    task automatic chk_idle(input string tag);
        chk({tag, "_blank"}, 32'(blank), 32'd1);
        chk({tag, "_idx"},   32'(scan_idx), 32'd0);
        chk({tag, "_sel"},   32'({sel_a, sel_b, sel_c}), 32'd0);
        chk({tag, "_fd"},    32'(frame_done), 32'd0);
    endtask

    // Checks one full 6-cycle position slot and leaves the bench at cycle 0
    // of the next slot. If edit_c is in the range 0..5, the mask is replaced
    // with edit_mask at that cycle.
    task automatic expect_pos(input string tag, input logic [2:0] exp_idx,
                              input logic exp_fd, input int edit_c,
                              input logic [7:0] edit_mask);
        for (int c = 0; c < 6; c++) begin
            chk({tag, "_blank"}, 32'(blank), (c < 2) ? 32'd1 : 32'd0);
            chk({tag, "_idx"},   32'(scan_idx), 32'(exp_idx));
            chk({tag, "_sel"},   32'({sel_a, sel_b, sel_c}), 32'(exp_idx));
            chk({tag, "_fd"},    32'(frame_done), (c == 0) ? 32'(exp_fd) : 32'd0);
            if (c == edit_c) digit_mask = edit_mask;
            tick();
        end
        $display("slot %s idx=%0d frame_done=%0d", tag, exp_idx, exp_fd);
    endtask

    initial begin
        rst_n      = 1'b0;
        en         = 1'b0;
        digit_mask = 8'h00;
        repeat (3) tick();
        chk_idle("rst_init");
        rst_n = 1'b1;
        tick();
        chk_idle("idle_after_rst");

        // Full scan with all eight positions.
        digit_mask = 8'hFF;
        en = 1'b1;
        tick();
        for (int p = 0; p < 8; p++) expect_pos("full", 3'(p), 1'b0, -1, 8'h00);
        expect_pos("full_wrap", 3'd0, 1'b1, -1, 8'h00);
        expect_pos("full", 3'd1, 1'b0, -1, 8'h00);
        en = 1'b0;
        tick();
        chk_idle("full_stop");

        // Sparse mask: positions 2, 5 and 7.
        digit_mask = 8'b1010_0100;
        en = 1'b1;
        tick();
        expect_pos("sparse", 3'd2, 1'b0, -1, 8'h00);
        expect_pos("sparse", 3'd5, 1'b0, -1, 8'h00);
        expect_pos("sparse", 3'd7, 1'b0, -1, 8'h00);
        expect_pos("sparse_wrap", 3'd2, 1'b1, -1, 8'h00);
        expect_pos("sparse", 3'd5, 1'b0, -1, 8'h00);
        en = 1'b0;
        tick();
        chk_idle("sparse_stop");

        // Single-bit mask: position 4 repeats and wraps on every slot.
        digit_mask = 8'b0001_0000;
        en = 1'b1;
        tick();
        expect_pos("single", 3'd4, 1'b0, -1, 8'h00);
        expect_pos("single_wrap", 3'd4, 1'b1, -1, 8'h00);
        expect_pos("single_wrap", 3'd4, 1'b1, -1, 8'h00);
        // Mid-scan asynchronous reset, applied between clock edges while
        // frame_done is high.
        chk("pre_rst_fd", 32'(frame_done), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_idle("async_rst");
        en = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        chk_idle("rst_release1");
        tick();
        chk_idle("rst_release2");
        $display("reset mid-scan checked");

        // Stop through en going low during SHOW of position 1.
        digit_mask = 8'hFF;
        en = 1'b1;
        tick();
        expect_pos("stop_en", 3'd0, 1'b0, -1, 8'h00);
        repeat (3) tick();
        chk("stop_en_show", 32'(blank), 32'd0);
        chk("stop_en_idx", 32'(scan_idx), 32'd1);
        en = 1'b0;
        tick();
        chk_idle("stop_en_next");
        tick();
        chk_idle("stop_en_hold");
        $display("stop via en checked");

        // Stop through the mask going to zero during SHOW of position 1.
        en = 1'b1;
        tick();
        expect_pos("stop_mask", 3'd0, 1'b0, -1, 8'h00);
        repeat (3) tick();
        chk("stop_mask_show", 32'(blank), 32'd0);
        chk("stop_mask_idx", 32'(scan_idx), 32'd1);
        digit_mask = 8'h00;
        tick();
        chk_idle("stop_mask_next");
        tick();
        chk_idle("stop_mask_hold");
        $display("stop via mask checked");

        // Live mask edit: bit 3 is cleared during SHOW of position 3.
        digit_mask = 8'hFF;
        tick();
        expect_pos("edit", 3'd0, 1'b0, -1, 8'h00);
        expect_pos("edit", 3'd1, 1'b0, -1, 8'h00);
        expect_pos("edit", 3'd2, 1'b0, -1, 8'h00);
        expect_pos("edit_clr", 3'd3, 1'b0, 3, 8'hF7);
        expect_pos("edit", 3'd4, 1'b0, -1, 8'h00);
        expect_pos("edit", 3'd5, 1'b0, -1, 8'h00);
        expect_pos("edit", 3'd6, 1'b0, -1, 8'h00);
        expect_pos("edit", 3'd7, 1'b0, -1, 8'h00);
        expect_pos("edit_wrap", 3'd0, 1'b1, -1, 8'h00);
        expect_pos("edit", 3'd1, 1'b0, -1, 8'h00);
        expect_pos("edit", 3'd2, 1'b0, -1, 8'h00);
        expect_pos("edit_skip3", 3'd4, 1'b0, -1, 8'h00);
        en = 1'b0;
        tick();
        chk_idle("edit_stop");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/decoder_scan_ctrl.md
# decoder_scan_ctrl

Sequencer that drives the A/B/C select inputs of the 3-8 decoder to time-multiplex eight output positions, such as digit strobes of a multiplexed seven-segment display. It walks the positions enabled in a mask in cyclic order. Each position is held for a programmable dwell, and a blanking gap separates positions so the decoder output never glitches onto a visible position. It sits between the board-level enable/mask registers and the decoder's select and enable pins.

## Interface
- SCAN_DIV, 50000, dwell per position in clk cycles; legal range 1..2^DIV_W-1
- BLANK_CYC, 8, blanking gap per position in clk cycles; legal range 1..255
- DIV_W, 16, width of the dwell counter
- clk  in  1  system clock, rising-edge
- rst_n  in  1  asynchronous active-low reset
- en  in  1  scan enable, level
- digit_mask  in  8  bit i=1 means position i is scanned
- sel_a  out  1  decoder select MSB (idx[2])
- sel_b  out  1  decoder select (idx[1])
- sel_c  out  1  decoder select LSB (idx[0])
- blank  out  1  1 = decoder disabled / output suppressed
- scan_idx  out  3  current position, equals {sel_a,sel_b,sel_c}
- frame_done  out  1  one-cycle pulse on frame wrap

## Operation
- FSM states: IDLE, BLANK, SHOW. All outputs are registered.
- Reset (async, immediate): state=IDLE, idx=0, sel=000, blank=1, frame_done=0, counters=0.
- IDLE:
  - blank=1.
  - If en=1 and digit_mask!=0: go to BLANK. idx=lowest set mask bit. frame_done=0.
- BLANK:
  - blank=1; sel already shows the new idx.
  - After BLANK_CYC cycles, go to SHOW.
- SHOW:
  - blank=0 for SCAN_DIV cycles.
  - Then idx=next set mask bit strictly after idx, searched cyclically 7→0. Go to BLANK.
- Frame wrap:
  - Defined as the search passing from 7 to 0, or returning to the same idx (single-bit mask).
  - frame_done=1 for exactly the first cycle of the following BLANK.
- Mask changes:
  - The mask is used only at index selection.
  - A position whose bit clears during its SHOW completes its dwell.
- en=0 or digit_mask==0 sampled in any state:
  - Next cycle: IDLE, blank=1, idx=0, frame_done=0.
  - Takes priority over the dwell and blank counters.
- Select lines change only on the transition into BLANK, never while blank=0.

## Timing
- Start: en=1 sampled at edge k in IDLE. After edge k: BLANK, blank=1, sel=first idx.
- blank falls after edge k+BLANK_CYC.
- Per-position period: BLANK_CYC+SCAN_DIV cycles, consisting of BLANK_CYC blanked cycles then SCAN_DIV shown cycles.
- Full frame with N mask bits set: N·(BLANK_CYC+SCAN_DIV) cycles.
- Stop latency: 1 cycle from en=0 or mask=0 sampled to blank=1.
- Next-index search is combinational over 8 bits and completes in the same cycle; no added latency.

## Configuration
- SCAN_FRAME_CNT_EN defined:
  - Adds output frame_cnt [7:0].
  - Increments on every frame_done pulse and wraps 255→0.
  - Resets to 0 on rst_n and on entry to IDLE.
- Undefined: port and counter absent. All other behaviour is identical.

## Test plan
All scenarios use SCAN_DIV=4, BLANK_CYC=2.
- Reset: rst_n=0 held mid-scan -> immediately blank=1, sel=000, scan_idx=0, frame_done=0; after release with en=0, outputs stay in that state.
- Full scan: mask=8'hFF, en=1 -> scan_idx 0,1,…,7,0. Each index: 2 cycles blank=1, then 4 cycles blank=0. frame_done is pulsed once, at the 7→0 transition, 48 cycles after start.
- Sparse mask: mask=8'b1010_0100 -> scan_idx 2,5,7,2,… frame_done is pulsed on the 7→2 BLANK entry; frame length is 18 cycles.
- Single bit: mask=8'b0001_0000 -> scan_idx stays 4; blank repeats 2 cycles high, 4 cycles low; frame_done is pulsed every 6 cycles.
- Mid-operation stop: en→0 during SHOW cycle 2 -> next cycle blank=1, IDLE, scan_idx=0. Repeating the scenario with mask→8'h00 gives the same response.
- Live mask edit: clear bit 3 during SHOW of idx 3 with mask=8'hFF -> idx 3 completes its 4 cycles, the scan continues 4,5,6,7,0,1,2,4, and no glitch appears on sel while blank=0.
